// File: rtl/pipeline_pkg.sv
// Shared types and constants for the XM23 decode-to-writeback chain.
// Optional build macro: PIPE_WB_BYPASS_EN (see pipeline_stage_chain).
package pipeline_pkg;

  localparam int DEF_PAYLOAD_W = 64;
  localparam int DEF_ENABLE_W  = 41;
  localparam int DEF_DATA_W    = 16;

  localparam int SEL_REG = 0;
  localparam int SEL_CON = 1;

  typedef struct packed {
    logic        wb;
    logic        slp;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
    logic        prpo;
    logic        dec;
    logic        inc;
    logic        rc;
    logic [2:0]  d;
    logic [2:0]  s;
    logic [2:0]  pr;
    logic [2:0]  f;
    logic [2:0]  t;
    logic [15:0] sa;
    logic [15:0] off;
    logic [6:0]  b;
  } decode_payload_t;

  typedef struct packed {
    logic                    valid;
    decode_payload_t         payload;
    logic [DEF_ENABLE_W-1:0] enable;
  } stage_t;

  localparam logic [7:0][DEF_DATA_W-1:0] CONSTANT_BANK = {
    16'hFFFF, 16'h0020, 16'h0010, 16'h0008,
    16'h0004, 16'h0002, 16'h0001, 16'h0000
  };

endpackage

// File: rtl/pipeline_stage_chain_pipe_stage_reg.sv
// One pipeline stage register: rst > flush > hold > load/bubble.
// Optional build macro: none.
module pipe_stage_reg
  import pipeline_pkg::*;
#(
  parameter int PW = DEF_PAYLOAD_W,
  parameter int EW = DEF_ENABLE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          hold,
  input  logic          load,
  input  logic          in_valid,
  input  logic [PW-1:0] in_payload,
  input  logic [EW-1:0] in_enable,
  output logic          valid_o,
  output logic [PW-1:0] payload_o,
  output logic [EW-1:0] enable_o
);

  logic          valid_q, valid_d;
  logic [PW-1:0] payload_q, payload_d;
  logic [EW-1:0] enable_q, enable_d;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    enable_d  = enable_q;
    if (!hold) begin
      if (load) begin
        valid_d   = in_valid;
        payload_d = in_payload;
        enable_d  = in_enable;
      end else begin
        // bubble keeps the old payload, only kills valid/enable
        valid_d  = 1'b0;
        enable_d = '0;
      end
    end
    if (flush) begin
      valid_d  = 1'b0;
      enable_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      enable_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      enable_q  <= enable_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;
  assign enable_o  = enable_q & {EW{valid_q}};

endmodule

// File: rtl/pipeline_stage_chain.sv
// XM23 decode-to-writeback shift chain with PSW and GPR/constant bank.
// Optional build macro: PIPE_WB_BYPASS_EN (write-through GPR/PSW outputs).
module pipeline_stage_chain
  import pipeline_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int PAYLOAD_W  = 64,
  parameter int ENABLE_W   = 41,
  parameter int STALL_W    = 8,
  parameter int DATA_W     = 16,
  parameter int NUM_GPR    = 8,
  localparam int SEL_W     = $clog2(NUM_GPR)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [STALL_W-1:0]                  stall_in,
  input  logic                                hold_in,
  input  logic [NUM_STAGES-1:0]               flush_in,
  input  logic                                dec_valid,
  input  logic [PAYLOAD_W-1:0]                dec_payload,
  input  logic [ENABLE_W-1:0]                 dec_enable,
  output logic [NUM_STAGES-1:0]               stage_valid_o,
  output logic [NUM_STAGES-1:0][PAYLOAD_W-1:0] stage_payload_o,
  output logic [NUM_STAGES-1:0][ENABLE_W-1:0] stage_enable_o,
  input  logic [DATA_W-1:0]                   psw_mask,
  input  logic [DATA_W-1:0]                   psw_in,
  output logic [DATA_W-1:0]                   psw_o,
  input  logic                                reg_write_enable,
  input  logic [SEL_W-1:0]                    reg_write_select,
  input  logic [DATA_W-1:0]                   reg_write_value,
  output logic [1:0][NUM_GPR-1:0][DATA_W-1:0] gprc_o,
  output logic [15:0]                         bubble_count_o
);

  logic stall;
  assign stall = |stall_in;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      pipe_stage_reg #(.PW(PAYLOAD_W), .EW(ENABLE_W)) u_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_in[k]),
        .hold      (hold_in),
        .load      (!stall),
        .in_valid  (dec_valid),
        .in_payload(dec_payload),
        .in_enable (dec_enable),
        .valid_o   (stage_valid_o[k]),
        .payload_o (stage_payload_o[k]),
        .enable_o  (stage_enable_o[k])
      );
    end else begin : g_next
      pipe_stage_reg #(.PW(PAYLOAD_W), .EW(ENABLE_W)) u_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_in[k]),
        .hold      (hold_in),
        .load      (1'b1),
        .in_valid  (stage_valid_o[k-1]),
        .in_payload(stage_payload_o[k-1]),
        .in_enable (stage_enable_o[k-1]),
        .valid_o   (stage_valid_o[k]),
        .payload_o (stage_payload_o[k]),
        .enable_o  (stage_enable_o[k])
      );
    end
  end

  logic [15:0] bubble_q, bubble_d;

  always_comb begin
    bubble_d = bubble_q;
    if (!hold_in && stall && bubble_q != 16'hFFFF) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  logic [DATA_W-1:0] psw_q, psw_d;
  logic [NUM_GPR-1:0][DATA_W-1:0] gpr_q, gpr_d;

  always_comb begin
    psw_d = (psw_q & ~psw_mask) | (psw_in & psw_mask);
    gpr_d = gpr_q;
    if (reg_write_enable) begin
      gpr_d[reg_write_select] = reg_write_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
      psw_q    <= '0;
      gpr_q    <= '0;
    end else begin
      bubble_q <= bubble_d;
      psw_q    <= psw_d;
      gpr_q    <= gpr_d;
    end
  end

  assign bubble_count_o = bubble_q;

`ifdef PIPE_WB_BYPASS_EN
  assign psw_o           = psw_d;
  assign gprc_o[SEL_REG] = gpr_d;
`else
  assign psw_o           = psw_q;
  assign gprc_o[SEL_REG] = gpr_q;
`endif

  for (genvar i = 0; i < NUM_GPR; i++) begin : g_con
    if (i < 8) begin : g_bank
      assign gprc_o[SEL_CON][i] = DATA_W'(CONSTANT_BANK[i]);
    end else begin : g_zero
      assign gprc_o[SEL_CON][i] = '0;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Directed self-checking bench for pipeline_stage_chain.
// Honours PIPE_WB_BYPASS_EN for the same-cycle GPR expectation.
module tb_pipeline_stage_chain;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           stall_in;
  logic                 hold_in;
  logic [2:0]           flush_in;
  logic                 dec_valid;
  logic [63:0]          dec_payload;
  logic [40:0]          dec_enable;
  logic [2:0]           stage_valid_o;
  logic [2:0][63:0]     stage_payload_o;
  logic [2:0][40:0]     stage_enable_o;
  logic [15:0]          psw_mask;
  logic [15:0]          psw_in;
  logic [15:0]          psw_o;
  logic                 reg_write_enable;
  logic [2:0]           reg_write_select;
  logic [15:0]          reg_write_value;
  logic [1:0][7:0][15:0] gprc_o;
  logic [15:0]          bubble_count_o;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  localparam logic [40:0] EA = 41'h0AB_CDEF_0123;
  localparam logic [40:0] EB = 41'h1F0_0000_00FF;
  localparam logic [7:0][15:0] CON = {
    16'hFFFF, 16'h0020, 16'h0010, 16'h0008,
    16'h0004, 16'h0002, 16'h0001, 16'h0000
  };

  pipeline_stage_chain dut (
    .clk             (clk),
    .rst             (rst),
    .stall_in        (stall_in),
    .hold_in         (hold_in),
    .flush_in        (flush_in),
    .dec_valid       (dec_valid),
    .dec_payload     (dec_payload),
    .dec_enable      (dec_enable),
    .stage_valid_o   (stage_valid_o),
    .stage_payload_o (stage_payload_o),
    .stage_enable_o  (stage_enable_o),
    .psw_mask        (psw_mask),
    .psw_in          (psw_in),
    .psw_o           (psw_o),
    .reg_write_enable(reg_write_enable),
    .reg_write_select(reg_write_select),
    .reg_write_value (reg_write_value),
    .gprc_o          (gprc_o),
    .bubble_count_o  (bubble_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic v, input logic [63:0] p,
                      input logic [40:0] e);
    dec_valid   = v;
    dec_payload = p;
    dec_enable  = e;
  endtask

  initial begin
    logic [15:0] r3_same;
    rst = 1'b1; stall_in = '0; hold_in = 1'b0; flush_in = '0;
    feed(1'b0, '0, '0);
    psw_mask = '0; psw_in = '0;
    reg_write_enable = 1'b0; reg_write_select = '0;
    reg_write_value = '0;
    tick();
    rst = 1'b0;

    // random traffic before reset
    for (int i = 0; i < 6; i++) begin
      feed(1'b1, {$urandom, $urandom}, 41'({$urandom, $urandom}));
      stall_in = 8'($urandom_range(0, 3));
      psw_mask = 16'hFFFF; psw_in = 16'($urandom);
      reg_write_enable = 1'b1;
      reg_write_select = 3'(i);
      reg_write_value = 16'($urandom) | 16'h1;
      tick();
    end

    // reset overrides hold, flush and writes
    rst = 1'b1; hold_in = 1'b1; flush_in = 3'b111; stall_in = 8'h04;
    reg_write_enable = 1'b1; reg_write_select = 3'd3;
    reg_write_value = 16'hABCD;
    tick();
    tick();
    rst = 1'b0; hold_in = 1'b0; flush_in = '0; stall_in = '0;
    reg_write_enable = 1'b0; psw_mask = '0; psw_in = '0;
    feed(1'b0, '0, '0);
    #1;
    chk("rst_valid", 64'(stage_valid_o), 64'd0);
    chk("rst_pay0", stage_payload_o[0], 64'd0);
    chk("rst_pay2", stage_payload_o[2], 64'd0);
    chk("rst_en1", 64'(stage_enable_o[1]), 64'd0);
    chk("rst_psw", 64'(psw_o), 64'd0);
    for (int i = 0; i < 8; i++) chk("rst_gpr", 64'(gprc_o[0][i]), 64'd0);
    chk("rst_bubble", 64'(bubble_count_o), 64'd0);
    for (int i = 0; i < 8; i++) chk("con", 64'(gprc_o[1][i]), 64'(CON[i]));

    // shift A1..A3
    feed(1'b1, 64'hA1, EA); tick();
    feed(1'b1, 64'hA2, EA); tick();
    feed(1'b1, 64'hA3, EA); tick();
    chk("sh_valid", 64'(stage_valid_o), 64'b111);
    chk("sh_pay2", stage_payload_o[2], 64'hA1);
    chk("sh_pay1", stage_payload_o[1], 64'hA2);
    chk("sh_pay0", stage_payload_o[0], 64'hA3);
    chk("sh_en2", 64'(stage_enable_o[2]), 64'(EA));
    feed(1'b0, 64'hA4, EA); tick();
    chk("inv_valid", 64'(stage_valid_o), 64'b110);
    chk("inv_pay0", stage_payload_o[0], 64'hA4);
    chk("inv_en0", 64'(stage_enable_o[0]), 64'd0);
    chk("inv_pay2", stage_payload_o[2], 64'hA2);

    // stall for two cycles
    feed(1'b1, 64'hB1, EB); tick();
    stall_in = 8'h04; feed(1'b1, 64'hB2, EB); tick();
    chk("st1_valid", 64'(stage_valid_o), 64'b010);
    tick();
    chk("st2_valid", 64'(stage_valid_o), 64'b100);
    chk("st2_pay0", stage_payload_o[0], 64'hB1);
    chk("st2_en0", 64'(stage_enable_o[0]), 64'd0);
    chk("st2_en1", 64'(stage_enable_o[1]), 64'd0);
    chk("st2_en2", 64'(stage_enable_o[2]), 64'(EB));
    chk("st2_bubble", 64'(bubble_count_o), 64'd2);
    stall_in = '0; tick();
    chk("st3_valid", 64'(stage_valid_o), 64'b001);
    chk("st3_pay0", stage_payload_o[0], 64'hB2);
    hold_in = 1'b1; stall_in = 8'h04; tick();
    chk("sth_valid", 64'(stage_valid_o), 64'b001);
    chk("sth_bubble", 64'(bubble_count_o), 64'd2);

    // hold with flush on stage 1
    hold_in = 1'b0; stall_in = '0;
    feed(1'b1, 64'hB3, EB); tick();
    feed(1'b1, 64'hB4, EB); tick();
    chk("pre_valid", 64'(stage_valid_o), 64'b111);
    hold_in = 1'b1; flush_in = 3'b010; feed(1'b1, 64'hC0, EA);
    tick();
    flush_in = '0; tick(); tick();
    chk("hf_valid", 64'(stage_valid_o), 64'b101);
    chk("hf_pay0", stage_payload_o[0], 64'hB4);
    chk("hf_pay1", stage_payload_o[1], 64'hB3);
    chk("hf_pay2", stage_payload_o[2], 64'hB2);
    chk("hf_en1", 64'(stage_enable_o[1]), 64'd0);
    hold_in = 1'b0; feed(1'b1, 64'hB5, EA); tick();
    chk("rs_valid", 64'(stage_valid_o), 64'b011);
    chk("rs_pay2", stage_payload_o[2], 64'hB3);
    chk("rs_en0", 64'(stage_enable_o[0]), 64'(EA));
    flush_in = 3'b100; feed(1'b1, 64'hB6, EA); tick();
    flush_in = '0;
    chk("fs_valid", 64'(stage_valid_o), 64'b011);
    chk("fs_pay2", stage_payload_o[2], 64'hB4);
    chk("fs_en2", 64'(stage_enable_o[2]), 64'd0);
    feed(1'b0, '0, '0);

    // PSW masked update
    psw_mask = 16'h000F; psw_in = 16'hFFFF; tick();
    psw_mask = '0; #1;
    chk("psw_low", 64'(psw_o), 64'h000F);
    psw_mask = 16'hFF00; psw_in = 16'h1200; tick();
    psw_mask = '0; #1;
    chk("psw_high", 64'(psw_o), 64'h120F);

    // GPR write timing
`ifdef PIPE_WB_BYPASS_EN
    r3_same = 16'h1234;
`else
    r3_same = 16'h0000;
`endif
    reg_write_enable = 1'b1; reg_write_select = 3'd3;
    reg_write_value = 16'h1234; #1;
    chk("r3_same", 64'(gprc_o[0][3]), 64'(r3_same));
    tick();
    reg_write_enable = 1'b0; #1;
    chk("r3_next", 64'(gprc_o[0][3]), 64'h1234);
    chk("r2_keep", 64'(gprc_o[0][2]), 64'd0);

    // reset beats a simultaneous write
    rst = 1'b1; reg_write_enable = 1'b1; reg_write_value = 16'h5555;
    tick();
    rst = 1'b0; reg_write_enable = 1'b0; #1;
    chk("rstw_r3", 64'(gprc_o[0][3]), 64'd0);
    chk("rstw_psw", 64'(psw_o), 64'd0);
    chk("rstw_bubble", 64'(bubble_count_o), 64'd0);

    // bubble counter saturation
    stall_in = 8'h01;
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_pre", 64'(bubble_count_o), 64'hFFFE);
    for (int i = 0; i < 4466; i++) tick();
    chk("sat_max", 64'(bubble_count_o), 64'hFFFF);
    tick();
    chk("sat_hold", 64'(bubble_count_o), 64'hFFFF);
    stall_in = '0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_chain.md
Name: pipeline_stage_chain

Overview:
Parametrised decode-to-writeback shift chain for the XM23 pipeline, carrying a packed decode payload and a functional-unit enable vector through NUM_STAGES stages. It adds per-stage valid bits, per-stage flush, global hold, a bubble counter and synchronous reset. It also owns the PSW (bit-masked update) and the GPR/constant bank. It sits between the decoder/pipeline controller and the execute/memory/writeback stages.

Parameters:
NUM_STAGES, 3, stages after decode (index 0 = execute, NUM_STAGES-1 = writeback)
PAYLOAD_W, 64, packed decode-field width (WB, SLP, N, Z, C, V, PRPO, DEC, INC, RC, D, S, PR, F, T, SA, OFF, B)
ENABLE_W, 41, functional-unit enable vector width
STALL_W, 8, stall request vector width
DATA_W, 16, register/PSW width
NUM_GPR, 8, general-purpose register count (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_in  in  STALL_W  any bit set: insert bubble at stage 0
hold_in  in  1  freeze entire chain (memory wait)
flush_in  in  NUM_STAGES  per-stage kill mask
dec_valid  in  1  decoder presents valid instruction
dec_payload  in  PAYLOAD_W  packed decode fields
dec_enable  in  ENABLE_W  decoded enables
stage_valid_o  out  NUM_STAGES  per-stage valid
stage_payload_o  out  NUM_STAGES x PAYLOAD_W  per-stage payload
stage_enable_o  out  NUM_STAGES x ENABLE_W  enables ANDed with stage valid
psw_mask  in  DATA_W  PSW bits to update
psw_in  in  DATA_W  new PSW values
psw_o  out  DATA_W  current PSW
reg_write_enable  in  1  GPR write strobe
reg_write_select  in  $clog2(NUM_GPR)  GPR index
reg_write_value  in  DATA_W  write data
gprc_o  out  2 x NUM_GPR x DATA_W  [0] = GPRs, [1] = constants
bubble_count_o  out  16  saturating count of inserted bubbles

Behaviour:
- Reset (rst=1 at posedge): all stage_valid_o=0, payloads=0, enables=0, psw_o=0, all GPRs=0, bubble_count_o=0. Reset overrides hold, flush and writes in the same cycle.
- Constant bank is combinational and never writable: {0, 1, 2, 4, 8, 16, 32, 0xFFFF} for indices 0..7. For NUM_GPR>8, the remaining entries are 0.
- Priority per stage, per posedge: rst > flush > hold > shift.
- Shift (hold_in=0): stage k takes stage k-1 for k≥1. Stage 0 takes dec_payload/dec_enable with valid=dec_valid when stall_in==0. When stall_in!=0, stage 0 gets a bubble: valid=0, enable=0, payload held. Contents of the last stage are discarded.
- Hold (hold_in=1): all stages retain their contents. stall_in is ignored and no bubble is counted.
- flush_in[k]=1: stage k's valid and enable are cleared at this posedge, after any shift, so the value arriving in stage k is killed. This applies during hold too.
- stage_enable_o[k] = enable[k] & {ENABLE_W{valid[k]}}. Latency is decode to stage k = k+1 clocks with no hold.
- bubble_count_o increments by 1 for each cycle with hold_in=0, rst=0 and stall_in!=0, and saturates at 0xFFFF.
- PSW: psw_o <= (psw_o & ~psw_mask) | (psw_in & psw_mask) every cycle, unaffected by hold.
- GPR write: if reg_write_enable, GPR[reg_write_select] <= reg_write_value, unaffected by hold and flush. Reads are registered (new value visible the cycle after the write).

Optional Feature:
PIPE_WB_BYPASS_EN
- Defined: gprc_o[0][reg_write_select] shows reg_write_value combinationally in the write cycle when reg_write_enable=1 (write-through). psw_o likewise shows the merged value combinationally.
- Undefined: all outputs are purely registered as described above.

Decomposition:
- Package pipeline_pkg holds:
  - typedef decode_payload_t: packed struct of the decode fields, width PAYLOAD_W
  - typedef stage_t: {valid, payload, enable}
  - CONSTANT_BANK localparam array
  - SEL_REG=0, SEL_CON=1
- Sub-module pipe_stage_reg: one stage register with rst/flush/hold/load inputs, instantiated NUM_STAGES times in a generate loop.
- The PSW/GPR bank stays in the top module.

Test Plan:
- Reset: drive rst=1 for 2 cycles after random traffic -> all valids 0, psw_o=0x0000, gprc_o[0] all 0, bubble_count_o=0; gprc_o[1][7]=0xFFFF.
- Shift: dec_valid=1, payloads 0xA1, 0xA2, 0xA3 on three consecutive cycles -> stage 2 payload 0xA1 at cycle 3, enables non-zero only where valid=1.
- Stall: stall_in=0x04 for 2 cycles mid-stream -> two valid=0 holes propagate down the chain, stage_enable_o=0 for them, bubble_count_o=2; stall_in=0x04 during hold_in=1 -> count unchanged.
- Hold+flush: hold_in=1 for 3 cycles with flush_in=3'b010 on the first -> stages 0 and 2 unchanged, stage 1 valid=0. Shifting resumes correctly after hold drops.
- PSW/GPR: psw_mask=0x000F, psw_in=0xFFFF -> psw_o=0x000F. Write R3=0x1234 -> visible next cycle, or same cycle with PIPE_WB_BYPASS_EN. Simultaneous rst and write -> R3=0.
- Saturation: force 70000 stall cycles -> bubble_count_o=0xFFFF and it does not wrap.
